// File: rtl/pll_reset_sequencer_pkg.sv
// Purpose: shared types and defaults for the PLL reset sequencer and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        DEBOUNCE,
        RELEASE,
        RUN,
        FAULT
    } seq_state_t;

    localparam int DEF_NUM_DOMAINS    = 4;
    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_LOCK_TIMEOUT   = 4096;
    localparam int DEF_STABLE_CYCLES  = 256;
    localparam int DEF_STAGGER_CYCLES = 8;
    localparam int DEF_MAX_RETRIES    = 3;
    localparam int DEF_CNT_W          = 8;

    // The single shared cycle counter must reach the longest terminal count
    // of any state; the extra bit keeps comparisons clear of wrap-around.
    function automatic int cnt_width(input int lock_timeout,
                                     input int stable_cycles,
                                     input int release_span);
        int m;
        m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        if (release_span > m)  m = release_span;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Purpose: bundle of PLL-side and domain-side signals of the reset sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level-based.
// master = sequencer (drives pll_rst/dom_rst_n/status), slave = PLL + domains + control.
import pll_seq_pkg::*;

interface pll_reset_sequencer_if #(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int CNT_W       = DEF_CNT_W
);
    logic                   sw_rst;
    logic                   pll_locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   ready;
    logic                   fault;
    logic [1:0]             retry_cnt;
    logic [CNT_W-1:0]       loss_cnt;

    modport master (
        input  sw_rst, pll_locked,
        output pll_rst, dom_rst_n, ready, fault, retry_cnt, loss_cnt
    );

    modport slave (
        output sw_rst, pll_locked,
        input  pll_rst, dom_rst_n, ready, fault, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for asynchronous level signals, async active-low clear.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk, rst_n (clears both stages to 0), d (async in), q (synchronized out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// Purpose: reset the PLL, qualify its lock, then release domain resets in staggered order.
// Latency: lock loss reaches ready/dom_rst_n 3 refclk cycles after the pin (2 sync + 1 reg).
// Backpressure: none; sw_rst is a level request that pins the sequence in PLL_RST while high.
// Ports: refclk, rst_n (async, active-low); bus.master: sw_rst, pll_locked in;
//        pll_rst, dom_rst_n, ready, fault, retry_cnt, loss_cnt out (all straight from flops).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);
    localparam int REL_SPAN = NUM_DOMAINS * STAGGER_CYCLES;
    localparam int CNT_BITS = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, REL_SPAN);

    typedef logic [CNT_BITS-1:0] cnt_t;

    localparam cnt_t RST_LAST    = cnt_t'(RST_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t STABLE_LAST = cnt_t'(STABLE_CYCLES - 1);
    localparam cnt_t REL_LAST    = cnt_t'(REL_SPAN - 1);

    logic                   lock_s;
    seq_state_t             state_q, state_nxt;
    cnt_t                   cnt_q, cnt_nxt;
    logic [1:0]             retry_q, retry_nxt;
    logic [CNT_W-1:0]       loss_q, loss_nxt;
    logic                   pll_rst_q, pll_rst_nxt;
    logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
    logic                   ready_q, ready_nxt;
    logic                   fault_q, fault_nxt;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            retry_q   <= retry_nxt;
            loss_q    <= loss_nxt;
            pll_rst_q <= pll_rst_nxt;
            dom_q     <= dom_nxt;
            ready_q   <= ready_nxt;
            fault_q   <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + cnt_t'(1);
        retry_nxt = retry_q;
        loss_nxt  = loss_q;

        if (bus.sw_rst) begin
            // Restart wins over every other event; holding it keeps the counter at 0.
            state_nxt = PLL_RST;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = DEBOUNCE;
                        cnt_nxt   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_nxt = retry_q + 2'd1;
                        state_nxt = (retry_nxt == 2'(MAX_RETRIES)) ? FAULT : PLL_RST;
                        cnt_nxt   = '0;
                    end
                end
                DEBOUNCE: begin
                    // A glitch is not a timeout: go back and wait again without a retry.
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state_nxt = PLL_RST;
                        cnt_nxt   = '0;
                    end else if (cnt_q == REL_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                RUN: begin
                    cnt_nxt = '0;
                    if (!lock_s) begin
                        state_nxt = PLL_RST;
                        if (loss_q != {CNT_W{1'b1}}) loss_nxt = loss_q + CNT_W'(1);
                    end
                end
                FAULT: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they land in flops and
        // line up with the state they belong to.
        pll_rst_nxt = (state_nxt == PLL_RST) || (state_nxt == FAULT);
        ready_nxt   = (state_nxt == RUN);
        fault_nxt   = (state_nxt == FAULT);
        dom_nxt     = '0;
        if (state_nxt == RUN) begin
            dom_nxt = '1;
        end else if (state_nxt == RELEASE) begin
            // Bit i is up from the cycle the counter shows (i+1)*STAGGER-1 onward.
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                dom_nxt[i] = (cnt_nxt >= cnt_t'((i + 1) * STAGGER_CYCLES - 1));
            end
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.dom_rst_n = dom_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: randomized self-checking bench for pll_reset_sequencer against a phase/elapsed-time model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_reset_sequencer;
    localparam int NUM_DOMAINS    = 4;
    localparam int RST_CYCLES     = 16;
    localparam int LOCK_TIMEOUT   = 4096;
    localparam int STABLE_CYCLES  = 256;
    localparam int STAGGER_CYCLES = 8;
    localparam int MAX_RETRIES    = 3;
    localparam int CNT_W          = 5;   // narrow so saturation is reachable quickly
    localparam int LOSS_MAX       = (1 << CNT_W) - 1;
    localparam int OUTW           = 1 + NUM_DOMAINS + 1 + 1 + 2 + CNT_W;

    localparam int P_RST = 0, P_WAIT = 1, P_DEB = 2, P_REL = 3, P_RUN = 4, P_FLT = 5;

    logic refclk;
    logic rst_n;

    pll_reset_sequencer_if #(.NUM_DOMAINS(NUM_DOMAINS), .CNT_W(CNT_W)) bus ();

    pll_reset_sequencer #(
        .NUM_DOMAINS    (NUM_DOMAINS),
        .RST_CYCLES     (RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .STAGGER_CYCLES (STAGGER_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .CNT_W          (CNT_W)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase, cycles spent in it, and what the lock
    // synchronizer has seen on the two previous edges.
    int   m_ph, m_el, m_retry, m_loss;
    logic l1, l2;

    // PLL behaviour: locks lock_delay cycles after pll_rst falls when enabled.
    logic pll_on;
    int   lock_delay;
    int   since_rel;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_RST; m_el = 0; m_retry = 0; m_loss = 0; l1 = 1'b0; l2 = 1'b0;
    endtask

    task automatic model_edge(input logic sw, input logic pin);
        logic lk;
        lk = l2;
        l2 = l1;
        l1 = pin;
        if (sw) begin
            m_ph = P_RST; m_el = 0; m_retry = 0;
        end else begin
            case (m_ph)
                P_RST:  if (m_el >= RST_CYCLES - 1) begin m_ph = P_WAIT; m_el = 0; end
                        else m_el++;
                P_WAIT: if (lk) begin m_ph = P_DEB; m_el = 0; end
                        else if (m_el >= LOCK_TIMEOUT - 1) begin
                            m_retry++;
                            m_ph = (m_retry >= MAX_RETRIES) ? P_FLT : P_RST;
                            m_el = 0;
                        end else m_el++;
                P_DEB:  if (!lk) begin m_ph = P_WAIT; m_el = 0; end
                        else if (m_el >= STABLE_CYCLES - 1) begin
                            m_ph = P_REL; m_el = 0; m_retry = 0;
                        end else m_el++;
                P_REL:  if (!lk) begin m_ph = P_RST; m_el = 0; end
                        else if (m_el >= NUM_DOMAINS * STAGGER_CYCLES - 1) begin
                            m_ph = P_RUN; m_el = 0;
                        end else m_el++;
                P_RUN:  if (!lk) begin
                            if (m_loss < LOSS_MAX) m_loss++;
                            m_ph = P_RST; m_el = 0;
                        end
                default: ;
            endcase
        end
    endtask

    function automatic logic [OUTW-1:0] exp_outs();
        logic [NUM_DOMAINS-1:0] dom;
        int nrel;
        dom = '0;
        if (m_ph == P_RUN) begin
            dom = '1;
        end else if (m_ph == P_REL) begin
            nrel = (m_el + 1) / STAGGER_CYCLES;
            if (nrel > NUM_DOMAINS) nrel = NUM_DOMAINS;
            dom = NUM_DOMAINS'((1 << nrel) - 1);
        end
        return {(m_ph == P_RST) || (m_ph == P_FLT), dom, m_ph == P_RUN, m_ph == P_FLT,
                2'(m_retry), CNT_W'(m_loss)};
    endfunction

    function automatic logic [OUTW-1:0] obs_outs();
        return {bus.pll_rst, bus.dom_rst_n, bus.ready, bus.fault, bus.retry_cnt, bus.loss_cnt};
    endfunction

    task automatic pll_drive();
        if (bus.pll_rst) since_rel = 0;
        else since_rel++;
        bus.pll_locked = pll_on && !bus.pll_rst && (since_rel >= lock_delay);
    endtask

    // One refclk cycle: model follows the inputs the DUT sampled, then compare.
    task automatic step();
        logic sw_s, pin_s;
        sw_s  = bus.sw_rst;
        pin_s = bus.pll_locked;
        @(posedge refclk);
        if (rst_n) model_edge(sw_s, pin_s);
        else       model_reset();
        #1;
        chk("outs", 64'(obs_outs()), 64'(exp_outs()));
        pll_drive();
    endtask

    task automatic sw_pulse();
        bus.sw_rst = 1'b1;
        step();
        bus.sw_rst = 1'b0;
    endtask

    task automatic run_to_ready(input string tag);
        for (int i = 0; i < 3000 && !bus.ready; i++) step();
        chk(tag, 64'(bus.ready), 64'(1));
    endtask

    initial begin
        int n;
        logic [OUTW-1:0] rst_vec;
        rst_vec = {1'b1, {(OUTW-1){1'b0}}};

        rst_n = 1'b0;
        bus.sw_rst = 1'b0;
        bus.pll_locked = 1'b0;
        pll_on = 1'b0;
        lock_delay = 100;
        since_rel = 0;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        chk("reset_state", 64'(obs_outs()), 64'(rst_vec));
        rst_n = 1'b1;

        // 1: clean bring-up, lock 100 cycles after pll_rst falls.
        pll_on = 1'b1;
        run_to_ready("t1_ready");
        chk("t1_dom", 64'(bus.dom_rst_n), 64'({NUM_DOMAINS{1'b1}}));

        // 2: PLL never locks -> three timeouts then FAULT; sw_rst clears it.
        pll_on = 1'b0;
        sw_pulse();
        n = 0;
        while (bus.pll_rst && n < 100) begin step(); n++; end
        chk("t2_rst_width", 64'(n), 64'(RST_CYCLES));
        for (int i = 0; i < 3 * (RST_CYCLES + LOCK_TIMEOUT) + 100 && !bus.fault; i++) step();
        chk("t2_fault", 64'(bus.fault), 64'(1));
        chk("t2_retry", 64'(bus.retry_cnt), 64'(3));
        repeat (20) step();
        chk("t2_fault_hold", 64'({bus.fault, bus.pll_rst}), 64'(2'b11));
        sw_pulse();
        chk("t2_sw_clear", 64'({bus.fault, bus.retry_cnt}), 64'(0));
        pll_on = 1'b1;
        lock_delay = $urandom_range(3, 300);
        run_to_ready("t2_ready");

        // 3: one-cycle glitch mid-debounce forces full requalification.
        lock_delay = $urandom_range(3, 200);
        sw_pulse();
        for (int i = 0; i < 2000 && !(m_ph == P_DEB && m_el == 198); i++) step();
        chk("t3_in_debounce", 64'(m_ph == P_DEB), 64'(1));
        bus.pll_locked = 1'b0;
        step();
        run_to_ready("t3_ready");
        chk("t3_retry", 64'(bus.retry_cnt), 64'(0));

        // 5a: lock loss mid-RELEASE with dom_rst_n = 0011.
        sw_pulse();
        for (int i = 0; i < 3000 && bus.dom_rst_n != NUM_DOMAINS'(3); i++) step();
        chk("t5_at_0011", 64'(bus.dom_rst_n), 64'(3));
        pll_on = 1'b0;
        bus.pll_locked = 1'b0;
        n = 0;
        while (bus.dom_rst_n != '0 && n < 10) begin step(); n++; end
        chk("t5_rel_drop_lat", 64'(n), 64'(3));
        chk("t5_rel_loss", 64'(bus.loss_cnt), 64'(0));
        pll_on = 1'b1;
        lock_delay = $urandom_range(3, 100);
        run_to_ready("t5_relock");

        // 5b: sw_rst on the same cycle the FSM sees lock loss in RUN.
        pll_on = 1'b0;
        bus.pll_locked = 1'b0;
        step();
        step();
        bus.sw_rst = 1'b1;
        step();
        bus.sw_rst = 1'b0;
        chk("t5_sw_loss", 64'({bus.ready, bus.loss_cnt}), 64'(0));
        pll_on = 1'b1;
        run_to_ready("t5_sw_relock");

        // 4: repeated lock loss in RUN, counter saturates.
        for (int k = 0; k < LOSS_MAX + 4; k++) begin
            repeat ($urandom_range(1, 20)) step();
            pll_on = 1'b0;
            bus.pll_locked = 1'b0;
            n = 0;
            while (bus.ready && n < 10) begin step(); n++; end
            if (k < 2) chk("t4_loss_lat", 64'(n), 64'(3));
            if (k < 2) chk("t4_loss_dom", 64'(bus.dom_rst_n), 64'(0));
            pll_on = 1'b1;
            lock_delay = $urandom_range(1, 60);
            run_to_ready("t4_relock");
        end
        chk("t4_loss_sat", 64'(bus.loss_cnt), 64'(LOSS_MAX));

        // 6: async reset between edges mid-RELEASE.
        sw_pulse();
        for (int i = 0; i < 3000 && bus.dom_rst_n != NUM_DOMAINS'(3); i++) step();
        chk("t6_at_0011", 64'(bus.dom_rst_n), 64'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", 64'(obs_outs()), 64'(rst_vec));
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        run_to_ready("t6_ready");
        chk("t6_loss", 64'(bus.loss_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
